call_stack_pusher: RTL and testbench
====================================

// Module: call_stack_pusher
// PURPOSE
// - Push-side counterpart of the RET/RETS/RETD pop path in the E0C6200 core.
// - Executes CALL/CALZ: pushes return address {PCP,PCSH,PCSL} to stack RAM, decrements SP by 3, loads target PC.
// - Sits between the instruction decoder and the shared RAM write port; pop logic consumes the exact layout written here.
// PARAMETERS
// - RAM_ADDR_W   12   RAM address width; stack addresses are {4'h0, sp}
// - PC_W         13   PC width: {PCB, PCP[3:0], PCS[7:0]}
// PORTS
// - clk          in   1    core clock
// - reset        in   1    async, active-high
// - clk_en       in   1    microstep enable; all state advances only when high
// - start        in   1    begin op; sampled in IDLE on clk_en
// - is_calz      in   1    1 = CALZ (page 0, bank 0); 0 = CALL (NBP/NPP)
// - imm          in   8    target PCS
// - pc_in        in   13   PC of the CALL/CALZ instruction
// - np_in        in   5    {NBP, NPP[3:0]}
// - sp_in        in   8    current SP
// - ram_addr     out  12   stack write address
// - ram_wdata    out  4    nibble to write
// - ram_we       out  1    write strobe, one clk_en step per nibble
// - sp_out       out  8    new SP; valid with sp_we
// - sp_we        out  1    SP load strobe
// - pc_out       out  13   new PC; valid with pc_we
// - pc_we        out  1    PC load strobe
// - busy         out  1    high from accepted start until done
// - done         out  1    one clk_en-step pulse at completion
// - stack_ovf    out  1    sticky SP-wrap flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; stack_ovf cleared.
// - Return addr: PCP = pc_in[11:8], PCS = pc_in[7:0]+1 mod 256 (wraps in page, no carry into PCP/PCB).
// - States, each advancing on one clk_en: IDLE -> PUSH_PCP -> PUSH_PCSH -> PUSH_PCSL -> JUMP -> IDLE.
// - IDLE: start & clk_en latches inputs, busy=1; start while busy ignored (no queueing).
// - PUSH_PCP: addr {0,sp-1}, wdata PCP, ram_we=1.
// - PUSH_PCSH: addr {0,sp-2}, wdata PCS[7:4], ram_we=1.
// - PUSH_PCSL: addr {0,sp-3}, wdata PCS[3:0], ram_we=1.
// - JUMP: sp_we=1, sp_out=sp-3; pc_we=1; done=1; busy drops on exit.
// - pc_out: CALL {np_in[4], np_in[3:0], imm}; CALZ {1'b0, 4'h0, imm}.
// - SP arithmetic 8-bit mod 256 (0x01 - 3 = 0xFE); addresses follow wrapped SP.
// - Latency: start to done = 4 clk_en steps; clk_en low freezes state and holds strobes.
// - Inputs latched at start; later changes have no effect on the op in flight.
// - Reset mid-op: strobes drop immediately, no further writes, SP/PC not updated.
// CONFIGURATION
// - CALL_STACK_OVF_DETECT_EN defined: stack_ovf set when any push address wraps (sp_in < 3);
//   sticky until reset; writes still performed.
// - Undefined: stack_ovf tied 0, no detect logic.
// TESTING
// - CALL imm=0x34, pc_in=0x074C, np=0x03, sp=0x47 -> RAM[0x46]=7, [0x45]=4, [0x44]=D; sp_out=0x44, pc_out=0x0334.
// - CALZ imm=0x80, pc_in=0x1A20, np=0x1F, sp=0x10 -> RAM[0x0F]=A, [0x0E]=2, [0x0D]=1; pc_out=0x0080.
// - pc_in=0x03FF, sp=0x20 -> pushes 3,0,0 (PCS wrap, PCP stays 3).
// - sp=0x01 -> writes 0x000, 0x0FF, 0x0FE; sp_out=0xFE; stack_ovf=1 only with _EN.
// - clk_en toggling 1/0 -> done after exactly 4 enabled steps; strobes held while frozen.
// - reset asserted in PUSH_PCSH -> ram_we drops at once, no SP/PC load, IDLE.

Source files
------------

// File: rtl/call_stack_pusher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | call_stack_pusher                                                        |
// | CALL/CALZ sequencer: pushes {PCP,PCSH,PCSL} below SP, then SP-=3 and     |
// | loads the target PC. Optional macro: CALL_STACK_OVF_DETECT_EN            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module call_stack_pusher #(
   parameter int RAM_ADDR_W = 12,
   parameter int PC_W       = 13
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic                  is_calz,
   input  logic [7:0]            imm,
   input  logic [PC_W-1:0]       pc_in,
   input  logic [4:0]            np_in,
   input  logic [7:0]            sp_in,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [3:0]            ram_wdata,
   output logic                  ram_we,
   output logic [7:0]            sp_out,
   output logic                  sp_we,
   output logic [PC_W-1:0]       pc_out,
   output logic                  pc_we,
   output logic                  busy,
   output logic                  done,
   output logic                  stack_ovf
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PUSH_PCP  = 3'd1,
      S_PUSH_PCSH = 3'd2,
      S_PUSH_PCSL = 3'd3,
      S_JUMP      = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      sp_q, sp_d;
   logic [3:0]      pcp_q, pcp_d;
   logic [7:0]      pcs_q, pcs_d;
   logic [PC_W-1:0] tgt_q, tgt_d;
   logic            accept;
   logic [7:0]      push_sp;
   logic            unused_pcb;

   // PCB is never pushed; the return bank is restored from NBP by the pop side.
   assign unused_pcb = pc_in[PC_W-1];
   assign accept     = (state_q == S_IDLE) && start && clk_en;

   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      pcp_d   = pcp_q;
      pcs_d   = pcs_q;
      tgt_d   = tgt_q;
      if (accept) begin
         state_d = S_PUSH_PCP;
         sp_d    = sp_in;
         pcp_d   = pc_in[11:8];
         pcs_d   = pc_in[7:0] + 8'd1;
         tgt_d   = is_calz ? PC_W'({5'b0_0000, imm}) : PC_W'({np_in, imm});
      end else if (clk_en) begin
         case (state_q)
            S_PUSH_PCP:  state_d = S_PUSH_PCSH;
            S_PUSH_PCSH: state_d = S_PUSH_PCSL;
            S_PUSH_PCSL: state_d = S_JUMP;
            S_JUMP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sp_q    <= 8'h00;
         pcp_q   <= 4'h0;
         pcs_q   <= 8'h00;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         sp_q    <= sp_d;
         pcp_q   <= pcp_d;
         pcs_q   <= pcs_d;
         tgt_q   <= tgt_d;
      end
   end

   // Strobes decode straight from state so an async reset kills them at once.
   always_comb begin
      push_sp   = 8'h00;
      ram_addr  = '0;
      ram_wdata = 4'h0;
      ram_we    = 1'b0;
      sp_out    = 8'h00;
      sp_we     = 1'b0;
      pc_out    = '0;
      pc_we     = 1'b0;
      done      = 1'b0;
      busy      = (state_q != S_IDLE);
      case (state_q)
         S_PUSH_PCP: begin
            push_sp   = sp_q - 8'd1;
            ram_wdata = pcp_q;
            ram_we    = 1'b1;
         end
         S_PUSH_PCSH: begin
            push_sp   = sp_q - 8'd2;
            ram_wdata = pcs_q[7:4];
            ram_we    = 1'b1;
         end
         S_PUSH_PCSL: begin
            push_sp   = sp_q - 8'd3;
            ram_wdata = pcs_q[3:0];
            ram_we    = 1'b1;
         end
         S_JUMP: begin
            sp_out = sp_q - 8'd3;
            sp_we  = 1'b1;
            pc_out = tgt_q;
            pc_we  = 1'b1;
            done   = 1'b1;
         end
         default: ;
      endcase
      if (ram_we)
         ram_addr = {{(RAM_ADDR_W-8){1'b0}}, push_sp};
   end

`ifdef CALL_STACK_OVF_DETECT_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (accept && (sp_in < 8'd3))
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovf_d;
   end

   assign stack_ovf = ovf_q;
`else
   assign stack_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_call_stack_pusher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_call_stack_pusher                                                     |
// | Directed CALL/CALZ vectors with a queue-based write/jump scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_call_stack_pusher;

`ifdef CALL_STACK_OVF_DETECT_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, clk_en, start, is_calz;
   logic [7:0]  imm, sp_in;
   logic [12:0] pc_in;
   logic [4:0]  np_in;
   logic [11:0] ram_addr;
   logic [3:0]  ram_wdata;
   logic        ram_we, sp_we, pc_we, busy, done, stack_ovf;
   logic [7:0]  sp_out;
   logic [12:0] pc_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] wq[$];   // {addr, nibble}
   logic [20:0] jq[$];   // {sp_out, pc_out}

   call_stack_pusher dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
      .is_calz(is_calz), .imm(imm), .pc_in(pc_in), .np_in(np_in), .sp_in(sp_in),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .sp_out(sp_out), .sp_we(sp_we), .pc_out(pc_out), .pc_we(pc_we),
      .busy(busy), .done(done), .stack_ovf(stack_ovf)
   );

   always #5 clk = ~clk;

   // Monitor: consumes one expected entry per enabled output step.
   logic        hold_chk = 1'b0;
   logic [41:0] snap;
   logic [41:0] cur;
   logic [15:0] wexp;
   logic [20:0] jexp;
   always @(negedge clk) begin
      cur = {ram_we, ram_addr, ram_wdata, sp_we, pc_we, done, busy, sp_out, pc_out};
      if (reset) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            n_cmp++;
            if (cur !== snap) begin
               n_bad++;
               $display("FAIL frozen_hold got=%h want=%h", cur, snap);
            end
         end
         if (clk_en && ram_we) begin
            n_cmp++;
            if (wq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write got addr=%h data=%h want none", ram_addr, ram_wdata);
            end else begin
               wexp = wq.pop_front();
               if ({ram_addr, ram_wdata} !== wexp) begin
                  n_bad++;
                  $display("FAIL ram_write got addr=%h data=%h want addr=%h data=%h",
                           ram_addr, ram_wdata, wexp[15:4], wexp[3:0]);
               end
            end
         end
         if (clk_en && (sp_we || pc_we || done)) begin
            n_cmp++;
            if (jq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_jump got sp=%h pc=%h want none", sp_out, pc_out);
            end else begin
               jexp = jq.pop_front();
               if ({sp_we, pc_we, done, sp_out, pc_out} !== {3'b111, jexp}) begin
                  n_bad++;
                  $display("FAIL jump got we=%b%b done=%b sp=%h pc=%h want 11 1 sp=%h pc=%h",
                           sp_we, pc_we, done, sp_out, pc_out, jexp[20:13], jexp[12:0]);
               end
            end
         end
         hold_chk = !clk_en && busy;
         snap     = cur;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic run_op(input logic calz, input logic [7:0] im, input logic [12:0] pc,
                         input logic [4:0] np, input logic [7:0] sp,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [7:0] esp, input logic [12:0] epc, input bit toggle);
      int steps;
      bit seen;
      wq.push_back(w0); wq.push_back(w1); wq.push_back(w2);
      jq.push_back({esp, epc});
      is_calz = calz; imm = im; pc_in = pc; np_in = np; sp_in = sp;
      start = 1'b1; clk_en = 1'b1;
      @(posedge clk); #1;
      steps = 1;
      seen  = 1'b0;
      // Scramble inputs: the op in flight must use the latched copies.
      is_calz = ~calz; imm = ~im; pc_in = ~pc; np_in = ~np; sp_in = ~sp;
      for (int c = 0; c < 40 && !seen; c++) begin
         start  = (c == 1);
         clk_en = toggle ? ((c % 2) == 1) : 1'b1;
         @(posedge clk); #1;
         if (clk_en) steps++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) begin
         n_cmp++; n_bad++;
         $display("FAIL done_timeout got=none want=done within 40 cycles");
      end else begin
         check("latency_steps", 64'(steps), 64'd4);
      end
      clk_en = 1'b1;
      @(posedge clk); #1;
      check("busy_after_jump", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b0; start = 1'b0; is_calz = 1'b0;
      imm = 8'h00; pc_in = 13'h0000; np_in = 5'h00; sp_in = 8'h00;
      #3;
      check("reset_outputs",
            {ram_we, ram_addr, ram_wdata, sp_we, pc_we, done, busy, sp_out, pc_out, stack_ovf},
            64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(1'b0, 8'h34, 13'h074C, 5'h03, 8'h47,
             {12'h046, 4'h7}, {12'h045, 4'h4}, {12'h044, 4'hD}, 8'h44, 13'h0334, 1'b0);
      run_op(1'b1, 8'h80, 13'h1A20, 5'h1F, 8'h10,
             {12'h00F, 4'hA}, {12'h00E, 4'h2}, {12'h00D, 4'h1}, 8'h0D, 13'h0080, 1'b0);
      run_op(1'b0, 8'h55, 13'h03FF, 5'h00, 8'h20,
             {12'h01F, 4'h3}, {12'h01E, 4'h0}, {12'h01D, 4'h0}, 8'h1D, 13'h0055, 1'b0);
      check("ovf_clear_no_wrap", 64'(stack_ovf), 64'd0);
      run_op(1'b0, 8'h12, 13'h0123, 5'h15, 8'h01,
             {12'h000, 4'h1}, {12'h0FF, 4'h2}, {12'h0FE, 4'h4}, 8'hFE, 13'h1512, 1'b0);
      check("ovf_after_wrap", 64'(stack_ovf), 64'(OVF_EN));
      run_op(1'b0, 8'hA5, 13'h0B10, 5'h0A, 8'h80,
             {12'h07F, 4'hB}, {12'h07E, 4'h1}, {12'h07D, 4'h1}, 8'h7D, 13'h0AA5, 1'b1);
      check("ovf_sticky", 64'(stack_ovf), 64'(OVF_EN));

      // Reset while sitting in PUSH_PCSH: only the PCP write is expected.
      wq.push_back({12'h03F, 4'h5});
      is_calz = 1'b0; imm = 8'h66; pc_in = 13'h0577; np_in = 5'h02; sp_in = 8'h40;
      start = 1'b1; clk_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("in_pcsh_we", 64'(ram_we), 64'd1);
      check("in_pcsh_addr", 64'(ram_addr), 64'h03E);
      clk_en = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("midop_reset_outputs",
            {ram_we, sp_we, pc_we, done, busy, stack_ovf}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      clk_en = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("idle_after_reset", 64'(busy), 64'd0);
      check("write_queue_drained", 64'(wq.size()), 64'd0);
      check("jump_queue_drained", 64'(jq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
